// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the HI/LO multiply/divide unit:
// op encodings, FSM states and fixed latency.
package cpu_pkg;

   localparam int XLEN       = 32;
   localparam int MULDIV_LAT = XLEN + 2;

   localparam logic [1:0] OP_MULTU = 2'd0;
   localparam logic [1:0] OP_MULT  = 2'd1;
   localparam logic [1:0] OP_DIVU  = 2'd2;
   localparam logic [1:0] OP_DIV   = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CALC,
      ST_FIX,
      ST_WRITE
   } md_state_e;

   function automatic logic op_is_div(input logic [1:0] op);
      return (op == OP_DIVU) || (op == OP_DIV);
   endfunction

   function automatic logic op_is_signed(input logic [1:0] op);
      return (op == OP_MULT) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared multiply/divide datapath:
// shift-add for multiply, restoring trial-subtract for divide.
module muldiv_step #(
   parameter int WIDTH = 32
) (
   input  logic               i_div,
   input  logic [2*WIDTH-1:0] i_acc,
   input  logic [WIDTH-1:0]   i_opnd,
   output logic [2*WIDTH-1:0] o_acc
);

   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_trial;
   logic [2*WIDTH:0] w_shl;

   assign w_sum   = {1'b0, i_acc[2*WIDTH-1:WIDTH]}
                  + {1'b0, i_opnd};
   assign w_shl   = {i_acc, 1'b0};
   assign w_trial = w_shl[2*WIDTH:WIDTH]
                  - {1'b0, i_opnd};

   // mul: acc = {partial, multiplier}; div: acc = {rem, dividend/quot}
   always_comb begin
      o_acc = i_acc;
      if (i_div) begin
         if (!w_trial[WIDTH])
            o_acc = {w_trial[WIDTH-1:0],
                     w_shl[WIDTH-1:1], 1'b1};
         else
            o_acc = w_shl[2*WIDTH-1:0];
      end else if (i_acc[0]) begin
         o_acc = {w_sum, i_acc[WIDTH-1:1]};
      end else begin
         o_acc = {1'b0, i_acc[2*WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/hilo_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit driving the HI/LO write port.
// Fixed WIDTH+2 cycle latency; cancellable while computing.
module hilo_muldiv
   import cpu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             cancel,
   output logic             busy,
   output logic [WIDTH-1:0] HI_out,
   output logic [WIDTH-1:0] LO_out,
   output logic             HIWrite,
   output logic             LOWrite
);

   localparam int CW = $clog2(WIDTH) + 1;

   md_state_e          r_state;
   md_state_e          w_next;
   logic [CW-1:0]      r_cnt;
   logic               r_div;
   logic               r_sgn_q;
   logic               r_sgn_r;
   logic               r_dz;
   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_opnd;
   logic [WIDTH-1:0]   r_a_raw;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic               r_wr;
   logic               r_busy;

   logic               w_accept;
   logic               w_last;
   logic               w_div_op;
   logic               w_sgn_op;
   logic [WIDTH-1:0]   w_abs_a;
   logic [WIDTH-1:0]   w_abs_b;
   logic [2*WIDTH-1:0] w_step;
   logic [2*WIDTH-1:0] w_neg_acc;
   logic [WIDTH-1:0]   w_fix_hi;
   logic [WIDTH-1:0]   w_fix_lo;

   assign w_div_op = op_is_div(op);
   assign w_sgn_op = op_is_signed(op);
   assign w_abs_a  = (w_sgn_op && A[WIDTH-1]) ? -A : A;
   assign w_abs_b  = (w_sgn_op && B[WIDTH-1]) ? -B : B;
   // WRITE's exit edge doubles as the idle sampling point so
   // back-to-back ops run at exactly WIDTH+2 cycles each
   assign w_accept = start &&
                     ((r_state == ST_IDLE) ||
                      (r_state == ST_WRITE));
   assign w_last   = (r_cnt == CW'(WIDTH - 1));

   muldiv_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .i_div  (r_div),
      .i_acc  (r_acc),
      .i_opnd (r_opnd),
      .o_acc  (w_step)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= ST_IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_IDLE:
            if (start) w_next = ST_CALC;
         ST_CALC:
            if (cancel)      w_next = ST_IDLE;
            else if (w_last) w_next = ST_FIX;
         ST_FIX:
            w_next = cancel ? ST_IDLE : ST_WRITE;
         ST_WRITE:
            w_next = start ? ST_CALC : ST_IDLE;
         default:
            w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt   <= '0;
         r_div   <= 1'b0;
         r_sgn_q <= 1'b0;
         r_sgn_r <= 1'b0;
         r_dz    <= 1'b0;
         r_a_raw <= '0;
         r_opnd  <= '0;
         r_acc   <= '0;
      end else if (w_accept) begin
         r_cnt   <= '0;
         r_div   <= w_div_op;
         r_sgn_q <= w_sgn_op & (A[WIDTH-1] ^ B[WIDTH-1]);
         r_sgn_r <= w_sgn_op & A[WIDTH-1];
         r_dz    <= w_div_op && (B == '0);
         r_a_raw <= A;
         r_opnd  <= w_div_op ? w_abs_b : w_abs_a;
         r_acc   <= {{WIDTH{1'b0}},
                     w_div_op ? w_abs_a : w_abs_b};
      end else if (r_state == ST_CALC) begin
         r_acc <= w_step;
         r_cnt <= r_cnt + CW'(1);
      end
   end

   assign w_neg_acc = -r_acc;

   always_comb begin
      w_fix_hi = r_acc[2*WIDTH-1:WIDTH];
      w_fix_lo = r_acc[WIDTH-1:0];
      unique case (1'b1)
         r_div && r_dz: begin
            w_fix_hi = r_a_raw;
            w_fix_lo = '1;
         end
         r_div && !r_dz: begin
            if (r_sgn_r) w_fix_hi = -r_acc[2*WIDTH-1:WIDTH];
            if (r_sgn_q) w_fix_lo = -r_acc[WIDTH-1:0];
         end
         !r_div: begin
            if (r_sgn_q) {w_fix_hi, w_fix_lo} = w_neg_acc;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hi   <= '0;
         r_lo   <= '0;
         r_wr   <= 1'b0;
         r_busy <= 1'b0;
      end else begin
         r_wr   <= (r_state == ST_FIX) && !cancel;
         r_busy <= (w_next != ST_IDLE);
         if ((r_state == ST_FIX) && !cancel) begin
            r_hi <= w_fix_hi;
            r_lo <= w_fix_lo;
         end
      end
   end

   assign busy    = r_busy;
   assign HI_out  = r_hi;
   assign LO_out  = r_lo;
   assign HIWrite = r_wr;
   assign LOWrite = r_wr;

endmodule
